demux2_stream_rtl: RTL and testbench

- Two-way stream demultiplexer, the distributing counterpart of the 2:1 select mux.
- Accepts one val/rdy input stream carrying a per-message select bit and routes each message to output port 0 or 1.
- Each output port has a one-entry registered buffer, so a stalled output never blocks traffic bound for the other port once that message is buffered.
- Used to steer processor response/data streams to two consumers (e.g. imem/dmem side paths).

---
 rtl/demux2_stream_pkg.sv | 15 +
 rtl/demux2_stream_buf_rtl.sv | 67 ++++++
 rtl/demux2_stream_rtl.sv | 100 ++++++++++
 tb/tb_demux2_stream_rtl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux2_stream_pkg.sv
// +----------------------------------------------------------------------+
// | demux2_stream_pkg : shared constants for the two-way stream demux     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package demux2_stream_pkg;

  localparam logic c_port0     = 1'b0;
  localparam logic c_port1     = 1'b1;
  localparam int   c_cnt_nbits = 16;

endpackage : demux2_stream_pkg

`default_nettype wire

// File: rtl/demux2_stream_buf_rtl.sv
// +----------------------------------------------------------------------+
// | demux2_stream_buf_rtl : one-entry pipe buffer, optional 16-bit count  |
// | Rev 1.0   option macro: DEMUX2_STREAM_RTL_COUNT_EN                    |
// +----------------------------------------------------------------------+
`default_nettype none

module demux2_stream_buf_rtl
  import demux2_stream_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
  ,
  output logic [c_cnt_nbits-1:0] cnt
`endif
);

  logic               r_full;
  logic [p_nbits-1:0] r_data;
  logic               w_enq_fire;
  logic               w_deq_fire;

  // A full entry can still accept when it is being drained this cycle.
  assign enq_rdy    = !r_full || deq_rdy;
  assign w_enq_fire = enq_val && enq_rdy;
  assign w_deq_fire = r_full && deq_rdy;

  assign deq_val = r_full;
  assign deq_msg = r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_enq_fire) begin
      r_full <= 1'b1;
      r_data <= enq_msg;
    end else if (w_deq_fire) begin
      r_full <= 1'b0;
    end
  end

`ifdef DEMUX2_STREAM_RTL_COUNT_EN
  logic [c_cnt_nbits-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_deq_fire) begin
      r_cnt <= r_cnt + c_cnt_nbits'(1);
    end
  end

  assign cnt = r_cnt;
`endif

endmodule : demux2_stream_buf_rtl

`default_nettype wire

// File: rtl/demux2_stream_rtl.sv
// +----------------------------------------------------------------------+
// | demux2_stream_rtl : val/rdy 1-to-2 stream demux with per-port buffers |
// | Rev 1.0   option macro: DEMUX2_STREAM_RTL_COUNT_EN                    |
// +----------------------------------------------------------------------+
`default_nettype none

module demux2_stream_rtl
  import demux2_stream_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_sel,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
  ,
  output logic [c_cnt_nbits-1:0] cnt0,
  output logic [c_cnt_nbits-1:0] cnt1
`endif
);

  logic w_enq_val0;
  logic w_enq_val1;
  logic w_enq_rdy0;
  logic w_enq_rdy1;

  // Case equality keeps an unknown select from writing either buffer;
  // synthesis reduces it to plain equality, so the fall-through is sel=1.
  assign w_enq_val0 = in_val && (in_sel === c_port0);
  assign w_enq_val1 = in_val && (in_sel === c_port1);

  always_comb begin
    in_rdy = 1'bx;
    if (in_sel === c_port0) begin
      in_rdy = w_enq_rdy0;
    end else if (in_sel === c_port1) begin
      in_rdy = w_enq_rdy1;
    end
  end

`ifdef DEMUX2_STREAM_RTL_COUNT_EN
  demux2_stream_buf_rtl #(.p_nbits(p_nbits)) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .enq_val (w_enq_val0),
    .enq_rdy (w_enq_rdy0),
    .enq_msg (in_msg),
    .deq_val (out0_val),
    .deq_rdy (out0_rdy),
    .deq_msg (out0_msg),
    .cnt     (cnt0)
  );

  demux2_stream_buf_rtl #(.p_nbits(p_nbits)) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .enq_val (w_enq_val1),
    .enq_rdy (w_enq_rdy1),
    .enq_msg (in_msg),
    .deq_val (out1_val),
    .deq_rdy (out1_rdy),
    .deq_msg (out1_msg),
    .cnt     (cnt1)
  );
`else
  demux2_stream_buf_rtl #(.p_nbits(p_nbits)) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .enq_val (w_enq_val0),
    .enq_rdy (w_enq_rdy0),
    .enq_msg (in_msg),
    .deq_val (out0_val),
    .deq_rdy (out0_rdy),
    .deq_msg (out0_msg)
  );

  demux2_stream_buf_rtl #(.p_nbits(p_nbits)) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .enq_val (w_enq_val1),
    .enq_rdy (w_enq_rdy1),
    .enq_msg (in_msg),
    .deq_val (out1_val),
    .deq_rdy (out1_rdy),
    .deq_msg (out1_msg)
  );
`endif

endmodule : demux2_stream_rtl

`default_nettype wire

// File: tb/tb_demux2_stream_rtl.sv
// +----------------------------------------------------------------------+
// | tb_demux2_stream_rtl : directed self-checking bench for the demux     |
// | Rev 1.0   option macro: DEMUX2_STREAM_RTL_COUNT_EN                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_demux2_stream_rtl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic        in_sel;
  logic [31:0] in_msg;
  logic        out0_val;
  logic        out0_rdy;
  logic [31:0] out0_msg;
  logic        out1_val;
  logic        out1_rdy;
  logic [31:0] out1_msg;
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  demux2_stream_rtl #(.p_nbits(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_sel   (in_sel),
    .in_msg   (in_msg),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge, then settle so checks sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_val = 1'b0; in_sel = 1'b0; in_msg = '0;
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    step(); step();
    rst = 1'b1;
    step();

    // reset / idle
    chk("rst_out0_val", 32'(out0_val), 32'd0);
    chk("rst_out1_val", 32'(out1_val), 32'd0);
    chk("rst_in_rdy",   32'(in_rdy),   32'd1);
    chk("rst_out0_msg", out0_msg, 32'd0);
    chk("rst_out1_msg", out1_msg, 32'd0);
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
`endif

    // one message per port, one cycle latency
    in_val = 1'b1; in_sel = 1'b0; in_msg = 32'hA5A5_A5A5;
    step();
    chk("t2_out0_val", 32'(out0_val), 32'd1);
    chk("t2_out0_msg", out0_msg, 32'hA5A5_A5A5);
    chk("t2_out1_val_a", 32'(out1_val), 32'd0);
    in_sel = 1'b1; in_msg = 32'h5A5A_5A5A;
    step();
    chk("t2_out0_val_drained", 32'(out0_val), 32'd0);
    chk("t2_out1_val", 32'(out1_val), 32'd1);
    chk("t2_out1_msg", out1_msg, 32'h5A5A_5A5A);
    in_val = 1'b0;
    step();
    chk("t2_out1_val_drained", 32'(out1_val), 32'd0);

    // stalled port 0 does not block port 1
    out0_rdy = 1'b0;
    in_val = 1'b1; in_sel = 1'b0; in_msg = 32'h1;
    #1 chk("t3_in_rdy_first", 32'(in_rdy), 32'd1);
    step();
    chk("t3_out0_msg1", out0_msg, 32'h1);
    in_msg = 32'h2;
    #1 chk("t3_in_rdy_blocked", 32'(in_rdy), 32'd0);
    in_sel = 1'b1; in_msg = 32'h3;
    #1 chk("t3_in_rdy_port1", 32'(in_rdy), 32'd1);
    step();
    chk("t3_out1_val", 32'(out1_val), 32'd1);
    chk("t3_out1_msg", out1_msg, 32'h3);
    chk("t3_out0_held_val", 32'(out0_val), 32'd1);
    chk("t3_out0_held_msg", out0_msg, 32'h1);
    out0_rdy = 1'b1; in_sel = 1'b0; in_msg = 32'h2;
    #1 chk("t3_in_rdy_drain_fill", 32'(in_rdy), 32'd1);
    step();
    chk("t3_out0_val_refill", 32'(out0_val), 32'd1);
    chk("t3_out0_msg2", out0_msg, 32'h2);
    chk("t3_out1_val_drained", 32'(out1_val), 32'd0);
    in_val = 1'b0;
    step();
    chk("t3_out0_val_empty", 32'(out0_val), 32'd0);
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    chk("t3_cnt0", 32'(cnt0), 32'd3);
    chk("t3_cnt1", 32'(cnt1), 32'd2);
`endif

    // back-to-back stream on port 1
    in_val = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_msg = 32'(i);
      #1 chk("t4_in_rdy", 32'(in_rdy), 32'd1);
      step();
      chk("t4_out1_val", 32'(out1_val), 32'd1);
      chk("t4_out1_msg", out1_msg, 32'(i));
    end
    in_val = 1'b0;
    step();
    chk("t4_out1_val_end", 32'(out1_val), 32'd0);
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    chk("t4_cnt1", 32'(cnt1), 32'd10);
`endif

    // reset with both buffers full, transfer offered in the reset cycle
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    in_val = 1'b1; in_sel = 1'b0; in_msg = 32'h11;
    step();
    in_sel = 1'b1; in_msg = 32'h22;
    step();
    chk("t5_full0", 32'(out0_val), 32'd1);
    chk("t5_full1", 32'(out1_val), 32'd1);
    rst = 1'b0; out0_rdy = 1'b1; in_sel = 1'b0; in_msg = 32'h33;
    step();
    rst = 1'b1; in_val = 1'b0;
    chk("t5_out0_val", 32'(out0_val), 32'd0);
    chk("t5_out1_val", 32'(out1_val), 32'd0);
    chk("t5_out0_msg", out0_msg, 32'd0);
    chk("t5_out1_msg", out1_msg, 32'd0);
`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    chk("t5_cnt0", 32'(cnt0), 32'd0);
    chk("t5_cnt1", 32'(cnt1), 32'd0);
`endif
    step();
    chk("t5_dropped", 32'(out0_val), 32'd0);
    out1_rdy = 1'b1;

`ifdef DEMUX2_STREAM_RTL_COUNT_EN
    // counter wrap on port 0
    in_val = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      in_msg = 32'(i);
      @(posedge clk);
    end
    #1 in_val = 1'b0;
    step();
    chk("t6_cnt0_max", 32'(cnt0), 32'h0000_FFFF);
    in_val = 1'b1; in_msg = 32'hDEAD_BEEF;
    step();
    in_val = 1'b0;
    step();
    chk("t6_cnt0_wrap", 32'(cnt0), 32'd0);
    chk("t6_cnt1_untouched", 32'(cnt1), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_demux2_stream_rtl

`default_nettype wire
